// File: rtl/arr_deser_pkg.sv
// Shared types for the arr_deser serial-to-packed-array deserializer.
// Build option ARR_DESER_PARITY_EN adds a trailing even-parity bit per frame.
package arr_deser_pkg;

   localparam int PKG_GROUPS = 2;
   localparam int PKG_LANES  = 4;
   localparam int FW         = PKG_GROUPS * PKG_LANES * 2;

   typedef logic [1:PKG_GROUPS][PKG_LANES:1][3:2] frame_t;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      PARITY  = 2'd1,
      STALL   = 2'd2
   } state_e;

endpackage

// File: rtl/arr_deser_shreg.sv
// Indexed frame register for arr_deser: writes bit idx on acc, tracks running parity,
// and empties on the clr strobe. Used unchanged with or without ARR_DESER_PARITY_EN.
module arr_deser_shreg
   import arr_deser_pkg::*;
#(
   parameter int FRAME_W = FW,
   parameter int IW      = $clog2(FRAME_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               acc,
   input  logic [IW-1:0]      idx,
   input  logic               din,
   output logic [FRAME_W-1:0] data,
   output logic [FRAME_W-1:0] dnxt,
   output logic               pnxt
);

   logic par;

   // dnxt folds in the bit being accepted now, so a frame can be handed off
   // on the same edge its final data bit arrives.
   always_comb begin
      dnxt = data;
      if (acc) dnxt[idx] = din;
   end

   assign pnxt = par ^ din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         par  <= 1'b0;
      end else if (clr) begin
         data <= '0;
         par  <= 1'b0;
      end else if (acc) begin
         data <= dnxt;
         par  <= pnxt;
      end
   end

endmodule

// File: rtl/arr_deser.sv
// Bit-serial to packed-array deserializer with a one-entry registered output slot.
// Define ARR_DESER_PARITY_EN to expect an even-parity bit after every frame.
module arr_deser
   import arr_deser_pkg::*;
#(
   parameter int GROUPS = PKG_GROUPS,
   parameter int LANES  = PKG_LANES
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sin,
   input  logic                          sin_vld,
   output logic                          sin_rdy,
   output logic [1:GROUPS][LANES:1][3:2] frm,
   output logic                          frm_vld,
   input  logic                          frm_rdy,
   output logic                          frm_err
);

   localparam int FRAME_W = GROUPS * LANES * 2;
   localparam int IW      = $clog2(FRAME_W);
   localparam int CW      = IW + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_W - 1);

   state_e             state;
   logic [CW-1:0]      cnt;
   logic [FRAME_W-1:0] data;
   logic [FRAME_W-1:0] dnxt;
   logic               pnxt;
   logic               acc;
   logic               sh_acc;
   logic               last;
   logic               done;
   logic               slot_free;
   logic               clr;

   assign acc       = sin_vld && sin_rdy;
   assign sh_acc    = acc && (state == COLLECT);
   assign last      = (cnt == LAST_IDX);
   assign slot_free = !frm_vld || frm_rdy;

`ifdef ARR_DESER_PARITY_EN
   logic err_q;
   logic held_err;

   assign done    = acc && (state == PARITY);
   assign frm_err = err_q;
`else
   logic unused_pnxt;

   assign done        = sh_acc && last;
   assign frm_err     = 1'b0;
   assign unused_pnxt = pnxt;
`endif

   // The frame register empties once its contents reach the output slot.
   assign clr = (done && slot_free) || (state == STALL && frm_vld && frm_rdy);

   arr_deser_shreg #(
      .FRAME_W (FRAME_W),
      .IW      (IW)
   ) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .acc   (sh_acc),
      .idx   (cnt[IW-1:0]),
      .din   (sin),
      .data  (data),
      .dnxt  (dnxt),
      .pnxt  (pnxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= COLLECT;
         cnt     <= '0;
         frm     <= '0;
         frm_vld <= 1'b0;
         sin_rdy <= 1'b1;
`ifdef ARR_DESER_PARITY_EN
         err_q    <= 1'b0;
         held_err <= 1'b0;
`endif
      end else begin
         if (frm_vld && frm_rdy) frm_vld <= 1'b0;

         case (state)
            COLLECT: begin
               if (sh_acc) begin
                  if (last) begin
                     cnt <= '0;
`ifdef ARR_DESER_PARITY_EN
                     state <= PARITY;
`endif
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            PARITY: begin
            end
            STALL: begin
               if (frm_vld && frm_rdy) begin
                  frm     <= data;
                  frm_vld <= 1'b1;
                  sin_rdy <= 1'b1;
                  state   <= COLLECT;
`ifdef ARR_DESER_PARITY_EN
                  err_q <= held_err;
`endif
               end
            end
            default: state <= COLLECT;
         endcase

         // Completion overrides the per-state updates above; a slot drained
         // this very cycle counts as free, giving back-to-back frames.
         if (done) begin
            if (slot_free) begin
               frm     <= dnxt;
               frm_vld <= 1'b1;
               state   <= COLLECT;
`ifdef ARR_DESER_PARITY_EN
               err_q <= pnxt;
`endif
            end else begin
               state   <= STALL;
               sin_rdy <= 1'b0;
`ifdef ARR_DESER_PARITY_EN
               held_err <= pnxt;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_arr_deser.sv
// Self-checking bench for arr_deser: table-driven frames plus hand-written corner sequences,
// with a frame scoreboard. Honors ARR_DESER_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_arr_deser;
   import arr_deser_pkg::*;

`ifdef ARR_DESER_PARITY_EN
   localparam int NB     = FW + 1;
   localparam bit PAR_ON = 1'b1;
`else
   localparam int NB     = FW;
   localparam bit PAR_ON = 1'b0;
`endif

   typedef struct {
      logic [15:0] data;
      logic        par;
      logic [15:0] exp;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sin;
   logic        sin_vld;
   logic        sin_rdy;
   frame_t      frm;
   logic        frm_vld;
   logic        frm_rdy;
   logic        frm_err;
   logic [15:0] frm_flat;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic [16:0] sb[$];

   assign frm_flat = frm;

   arr_deser dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sin     (sin),
      .sin_vld (sin_vld),
      .sin_rdy (sin_rdy),
      .frm     (frm),
      .frm_vld (frm_vld),
      .frm_rdy (frm_rdy),
      .frm_err (frm_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic bit_of(input logic [15:0] d, input logic p, input int k);
      if (k < FW) return d[k];
      return p;
   endfunction

   function automatic logic model_err(input logic [15:0] d, input logic p);
      if (PAR_ON) return (^d) ^ p;
      return 1'b0;
   endfunction

   task automatic push(input logic [15:0] d, input logic p);
      sb.push_back({model_err(d, p), d});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Holds the bit with sin_vld=1 until an edge where sin_rdy was high.
   task automatic send_bit(input logic b);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      sin     = b;
      sin_vld = 1'b1;
      while (!ok && n < 200) begin
         if (sin_rdy) ok = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      sin_vld = 1'b0;
      chk("send_bit_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic send_bits(input logic [15:0] d, input logic p, input int from, input int to);
      for (int k = from; k < to; k++) send_bit(bit_of(d, p, k));
   endtask

   // Scoreboard pop on each output handshake, plus hold-stability check while stalled.
   logic        hold_v = 1'b0;
   logic [16:0] hold_d;
   logic [16:0] e;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) chk("hold_stable", {15'd0, frm_err, frm_flat}, {15'd0, hold_d});
         if (frm_vld && frm_rdy) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame", {16'd0, frm_flat}, 32'hDEAD_BEEF);
            end else begin
               e = sb.pop_front();
               chk("frame_data", {16'd0, frm_flat}, {16'd0, e[15:0]});
               chk("frame_err", {31'd0, frm_err}, {31'd0, e[16]});
            end
         end
         hold_v = frm_vld && !frm_rdy;
         hold_d = {frm_err, frm_flat};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      int   c0;
      int   n;

      tbl[0] = '{data: 16'hA5C3, par: 1'b0, exp: 16'hA5C3, exp_err: 1'b0};
      tbl[1] = '{data: 16'h0000, par: 1'b0, exp: 16'h0000, exp_err: 1'b0};
      tbl[2] = '{data: 16'hFFFF, par: 1'b1, exp: 16'hFFFF, exp_err: 1'b1};
      tbl[3] = '{data: 16'h8001, par: 1'b0, exp: 16'h8001, exp_err: 1'b0};
      tbl[4] = '{data: 16'h0003, par: 1'b0, exp: 16'h0003, exp_err: 1'b0};
      tbl[5] = '{data: 16'h0003, par: 1'b1, exp: 16'h0003, exp_err: 1'b1};

      rst_n   = 1'b0;
      sin     = 1'b0;
      sin_vld = 1'b0;
      frm_rdy = 1'b0;
      idle(3);
      chk("rst_frm", {16'd0, frm_flat}, 32'd0);
      chk("rst_vld", {31'd0, frm_vld}, 32'd0);
      chk("rst_err", {31'd0, frm_err}, 32'd0);
      chk("rst_sin_rdy", {31'd0, sin_rdy}, 32'd1);
      rst_n = 1'b1;
      idle(1);

      // Test 1: single frame, latency and bit placement
      frm_rdy = 1'b1;
      push(16'hA5C3, 1'b0);
      send_bits(16'hA5C3, 1'b0, 0, NB - 1);
      chk("t1_vld_before_last", {31'd0, frm_vld}, 32'd0);
      send_bits(16'hA5C3, 1'b0, NB - 1, NB);
      chk("t1_vld_latency", {31'd0, frm_vld}, 32'd1);
      chk("t1_frm", {16'd0, frm_flat}, 32'h0000_A5C3);
      chk("t1_elem_2_1_2", {31'd0, frm[2][1][2]}, 32'd1);
      chk("t1_elem_1_4_3", {31'd0, frm[1][4][3]}, 32'd1);
      idle(2);

      // Test 2: two frames with a full slot -> stall, then release
      frm_rdy = 1'b0;
      push(16'h1234, 1'b0);
      push(16'h5678, 1'b0);
      send_bits(16'h1234, 1'b0, 0, NB);
      send_bits(16'h5678, 1'b0, 0, NB);
      chk("t2_sin_rdy_stall", {31'd0, sin_rdy}, 32'd0);
      chk("t2_frm_holds_1", {16'd0, frm_flat}, 32'h0000_1234);
      idle(3);
      chk("t2_still_stalled", {31'd0, sin_rdy}, 32'd0);
      frm_rdy = 1'b1;
      idle(1);
      frm_rdy = 1'b0;
      chk("t2_frm_2", {16'd0, frm_flat}, 32'h0000_5678);
      chk("t2_vld_2", {31'd0, frm_vld}, 32'd1);
      chk("t2_sin_rdy_back", {31'd0, sin_rdy}, 32'd1);
      idle(2);
      frm_rdy = 1'b1;
      idle(2);

      // Test 3: completion in the same cycle the slot drains
      frm_rdy = 1'b0;
      push(16'h9C3E, 1'b0);
      push(16'h0F1E, 1'b0);
      send_bits(16'h9C3E, 1'b0, 0, NB);
      send_bits(16'h0F1E, 1'b0, 0, NB - 1);
      chk("t3_vld_pre", {31'd0, frm_vld}, 32'd1);
      frm_rdy = 1'b1;
      send_bits(16'h0F1E, 1'b0, NB - 1, NB);
      chk("t3_vld_cont", {31'd0, frm_vld}, 32'd1);
      chk("t3_frm_new", {16'd0, frm_flat}, 32'h0000_0F1E);
      chk("t3_no_stall", {31'd0, sin_rdy}, 32'd1);
      idle(2);

      // Test 4: sin_vld toggling every cycle, junk on idle cycles
      push(16'hA5C3, 1'b0);
      c0 = cyc;
      for (int k = 0; k < NB; k++) begin
         send_bit(bit_of(16'hA5C3, 1'b0, k));
         if (k < NB - 1) begin
            sin = ~sin;
            idle(1);
         end
      end
      chk("t4_cycles", cyc - c0, 2 * NB - 1);
      chk("t4_vld", {31'd0, frm_vld}, 32'd1);
      chk("t4_frm", {16'd0, frm_flat}, 32'h0000_A5C3);
      idle(2);

      // Test 5: reset with a held frame and a partial frame in flight
      frm_rdy = 1'b0;
      send_bits(16'hBEEF, 1'b0, 0, NB);
      send_bits(16'hFFFF, 1'b0, 0, 7);
      rst_n = 1'b0;
      idle(2);
      chk("t5_rst_vld", {31'd0, frm_vld}, 32'd0);
      chk("t5_rst_frm", {16'd0, frm_flat}, 32'd0);
      chk("t5_rst_sin_rdy", {31'd0, sin_rdy}, 32'd1);
      rst_n = 1'b1;
      idle(1);
      frm_rdy = 1'b1;
      push(16'h0001, 1'b0);
      send_bits(16'h0001, 1'b0, 0, NB);
      chk("t5_frm", {16'd0, frm_flat}, 32'h0000_0001);
      idle(2);

      // Table-driven frames (parity cases meaningful with ARR_DESER_PARITY_EN)
      for (int i = 0; i < 6; i++) begin
         sb.push_back({(PAR_ON ? tbl[i].exp_err : 1'b0), tbl[i].exp});
         send_bits(tbl[i].data, tbl[i].par, 0, NB);
         idle(int'($urandom_range(0, 2)));
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         idle(1);
         n++;
      end
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
